// File: rtl/rx8b9b_link_arbiter_pkg.sv
// Shared types and constants for the 8b9b link arbiter.
package rx8b9b_link_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS  = 3'd1,
    ST_ABORT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_GAP   = 3'd4
  } arbState_t;

  localparam logic [7:0] ABORT_FILL  = 8'h00;
  localparam int         ABORT_CNT_W = 16;
  localparam int         GAP_CNT_W   = 4;

endpackage

// File: rtl/rx8b9b_link_arbiter_rr_pick.sv
// Rotating priority encoder: first requester after lastGrant, wrapping modulo N.
module rx8b9b_link_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] lastGrant,
  output logic [IDX_W-1:0] nextGrant,
  output logic             found
);

  int               cand;
  logic [IDX_W-1:0] candIdx;

  always_comb begin
    found     = 1'b0;
    nextGrant = lastGrant;
    cand      = 0;
    candIdx   = '0;
    // lastGrant itself is searched last, so a lone requester keeps winning
    for (int i = 1; i <= N; i++) begin
      cand    = (int'(lastGrant) + i) % N;
      candIdx = IDX_W'(cand);
      if (!found && req[candIdx]) begin
        found     = 1'b1;
        nextGrant = candIdx;
      end
    end
  end

endmodule

// File: rtl/rx8b9b_link_arbiter.sv
// Frame-granular round-robin arbiter sharing one 8b9b transmit link among N
// AXI-stream byte sources, with inter-frame gap and stall-abort watchdog.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no grant active; pick next requester round-robin
// ST_PASS  | granted source passed through combinationally to the link
// ST_ABORT | stalled frame terminated with a filler byte carrying TLAST
// ST_FLUSH | discard the rest of the aborted source's frame
// ST_GAP   | forced idle between frames so the receiver sees idle symbols
module rx8b9b_link_arbiter
  import rx8b9b_link_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int MIN_GAP = 2,
  parameter int TIMEOUT = 1024,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           S_AXIS_TVALID,
  output logic [N-1:0]           S_AXIS_TREADY,
  input  logic [8*N-1:0]         S_AXIS_TDATA,
  input  logic [N-1:0]           S_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic [7:0]             M_AXIS_TDATA,
  output logic                   M_AXIS_TLAST,
  output logic [IDX_W-1:0]       grant,
  output logic                   busy,
  output logic                   abortStrobe,
  output logic [ABORT_CNT_W-1:0] abortCount
);

  localparam int                     STALL_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [STALL_W-1:0]     STALL_LAST  = STALL_W'(TIMEOUT - 1);
  localparam logic [GAP_CNT_W-1:0]   GAP_LOAD    = (MIN_GAP > 0) ? GAP_CNT_W'(MIN_GAP - 1) : '0;
  localparam arbState_t              AFTER_FRAME = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;

  arbState_t              state, stateNext;
  logic [IDX_W-1:0]       grantReg, pickIdx;
  logic                   pickFound;
  logic [STALL_W-1:0]     stallCnt, stallNext;
  logic [GAP_CNT_W-1:0]   gapCnt, gapNext;
  logic [ABORT_CNT_W-1:0] abortCnt;
  logic                   enterAbort;
  logic                   srcValid, srcLast;
  logic [7:0]             srcData;

  rx8b9b_link_arbiter_rr_pick #(.N(N), .IDX_W(IDX_W)) uPick (
    .req       (S_AXIS_TVALID),
    .lastGrant (grantReg),
    .nextGrant (pickIdx),
    .found     (pickFound)
  );

  assign srcValid   = S_AXIS_TVALID[grantReg];
  assign srcLast    = S_AXIS_TLAST[grantReg];
  assign srcData    = S_AXIS_TDATA[{grantReg, 3'b000} +: 8];
  assign enterAbort = (state == ST_PASS) && (stateNext == ST_ABORT);

  always_comb begin
    stateNext     = state;
    stallNext     = stallCnt;
    gapNext       = gapCnt;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    case (state)
      ST_IDLE: begin
        stallNext = '0;
        if (pickFound) stateNext = ST_PASS;
      end
      ST_PASS: begin
        M_AXIS_TVALID           = srcValid;
        M_AXIS_TDATA            = srcData;
        M_AXIS_TLAST            = srcLast;
        S_AXIS_TREADY[grantReg] = M_AXIS_TREADY;
        // a valid source under backpressure is not stalled
        if (srcValid) begin
          stallNext = '0;
          if (M_AXIS_TREADY && srcLast) begin
            stateNext = AFTER_FRAME;
            gapNext   = GAP_LOAD;
          end
        end else if (stallCnt == STALL_LAST) begin
          stateNext = ST_ABORT;
          stallNext = '0;
        end else begin
          stallNext = stallCnt + 1'b1;
        end
      end
      ST_ABORT: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = ABORT_FILL;
        M_AXIS_TLAST  = 1'b1;
        stallNext     = '0;
        if (M_AXIS_TREADY) stateNext = ST_FLUSH;
      end
      ST_FLUSH: begin
        S_AXIS_TREADY[grantReg] = 1'b1;
        if (srcValid) begin
          stallNext = '0;
          if (srcLast) begin
            stateNext = AFTER_FRAME;
            gapNext   = GAP_LOAD;
          end
        end else if (stallCnt == STALL_LAST) begin
          stateNext = AFTER_FRAME;
          gapNext   = GAP_LOAD;
          stallNext = '0;
        end else begin
          stallNext = stallCnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (gapCnt == '0) stateNext = ST_IDLE;
        else gapNext = gapCnt - 1'b1;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grantReg    <= IDX_W'(N - 1);
      stallCnt    <= '0;
      gapCnt      <= '0;
      abortStrobe <= 1'b0;
      abortCnt    <= '0;
    end else begin
      state       <= stateNext;
      stallCnt    <= stallNext;
      gapCnt      <= gapNext;
      abortStrobe <= enterAbort;
      if (state == ST_IDLE && pickFound) grantReg <= pickIdx;
      if (enterAbort && abortCnt != '1) abortCnt <= abortCnt + 1'b1;
    end
  end

  assign grant      = grantReg;
  assign abortCount = abortCnt;
  assign busy       = (state == ST_PASS) || (state == ST_ABORT) || (state == ST_FLUSH);

endmodule

// File: tb/tb_rx8b9b_link_arbiter.sv
// Directed bench for rx8b9b_link_arbiter: per-source beat queues drive stimulus,
// an expected-beat scoreboard checks every byte reaching the link.
module tb_rx8b9b_link_arbiter;

  localparam int N       = 4;
  localparam int MIN_GAP = 2;
  localparam int TIMEOUT = 16;
  localparam int IDX_W   = 2;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         idle;
  } srcBeat_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         src;
    logic       isAbort;
    int         cnt;
  } expBeat_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     sValid, sReady, sLast;
  logic [8*N-1:0]   sData;
  logic             mValid, mReady, mLast;
  logic [7:0]       mData;
  logic [IDX_W-1:0] grant;
  logic             busy, abortStrobe;
  logic [15:0]      abortCount;

  srcBeat_t srcQ[N][$];
  expBeat_t sb[$];
  int   errors = 0, checks = 0, cycleNo = 0, lastEnd = -100, strobeCycles = 0;
  logic prevLast = 1'b1;

  rx8b9b_link_arbiter #(.N(N), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .S_AXIS_TVALID (sValid),
    .S_AXIS_TREADY (sReady),
    .S_AXIS_TDATA  (sData),
    .S_AXIS_TLAST  (sLast),
    .M_AXIS_TVALID (mValid),
    .M_AXIS_TREADY (mReady),
    .M_AXIS_TDATA  (mData),
    .M_AXIS_TLAST  (mLast),
    .grant         (grant),
    .busy          (busy),
    .abortStrobe   (abortStrobe),
    .abortCount    (abortCount)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic srcPush(input int src, input logic [7:0] data, input logic last, input int idle);
    srcBeat_t b;
    b.data = data; b.last = last; b.idle = idle;
    srcQ[src].push_back(b);
  endtask

  task automatic expPush(input logic [7:0] data, input logic last, input int src,
                         input logic isAbort, input int cnt);
    expBeat_t e;
    e.data = data; e.last = last; e.src = src; e.isAbort = isAbort; e.cnt = cnt;
    sb.push_back(e);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < N; i++) n += srcQ[i].size();
    return n;
  endfunction

  // Drive sources from their queues, then sample the settled link mid-low-phase.
  task automatic cycleBegin();
    expBeat_t e;
    srcBeat_t b;
    for (int i = 0; i < N; i++) begin
      if (srcQ[i].size() > 0 && srcQ[i][0].idle == 0) begin
        sValid[i] = 1'b1; sData[8*i +: 8] = srcQ[i][0].data; sLast[i] = srcQ[i][0].last;
      end else begin
        sValid[i] = 1'b0; sData[8*i +: 8] = 8'h00; sLast[i] = 1'b0;
      end
    end
    #1;
    if (abortStrobe === 1'b1) strobeCycles++;
    if (mValid === 1'b1 && mReady === 1'b1) begin
      check("beat_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("m_data", mData, e.data);
        check("m_last", mLast, e.last);
        check("grant", grant, e.src);
        check("abort_strobe", abortStrobe, e.isAbort);
        if (e.isAbort) check("abort_count", abortCount, e.cnt);
      end
      if (prevLast) check("frame_gap", (cycleNo - lastEnd) >= MIN_GAP + 2, 1);
      prevLast = mLast;
      if (mLast) lastEnd = cycleNo;
    end
    for (int i = 0; i < N; i++) begin
      if (sValid[i] && sReady[i]) begin
        void'(srcQ[i].pop_front());
      end else if (srcQ[i].size() > 0 && srcQ[i][0].idle > 0) begin
        b = srcQ[i][0]; b.idle--; srcQ[i][0] = b;
      end
    end
  endtask

  task automatic cycleEnd();
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic step();
    cycleBegin();
    cycleEnd();
  endtask

  task automatic runDrain(input string tag, input int budget);
    int n = 0;
    while (pending() > 0 || sb.size() > 0) begin
      if (n >= budget) break;
      step();
      n++;
    end
    check(tag, pending() + sb.size(), 0);
  endtask

  initial begin
    int n;
    sValid = '0; sData = '0; sLast = '0; mReady = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_mvalid", mValid, 0);
    check("rst_mdata", mData, 0);
    check("rst_mlast", mLast, 0);
    check("rst_sready", sReady, 0);
    check("rst_grant", grant, N - 1);
    check("rst_busy", busy, 0);
    check("rst_strobe", abortStrobe, 0);
    check("rst_count", abortCount, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // single 3-byte frame from source 0, one-cycle arbitration latency
    srcPush(0, 8'hAA, 1'b0, 0); srcPush(0, 8'hBB, 1'b0, 0); srcPush(0, 8'hCC, 1'b1, 0);
    expPush(8'hAA, 1'b0, 0, 1'b0, 0); expPush(8'hBB, 1'b0, 0, 1'b0, 0); expPush(8'hCC, 1'b1, 0, 1'b0, 0);
    cycleBegin();
    check("t1_idle_mvalid", mValid, 0);
    check("t1_idle_sready", sReady, 0);
    check("t1_idle_busy", busy, 0);
    cycleEnd();
    cycleBegin();
    check("t1_pass_busy", busy, 1);
    check("t1_pass_grant", grant, 0);
    cycleEnd();
    runDrain("t1_drained", 50);

    // sources 0..2 contending with 1-byte frames; source 3 idle and skipped
    srcPush(0, 8'h01, 1'b1, 0); srcPush(0, 8'h04, 1'b1, 0);
    srcPush(1, 8'h02, 1'b1, 0); srcPush(1, 8'h05, 1'b1, 0);
    srcPush(2, 8'h03, 1'b1, 0); srcPush(2, 8'h06, 1'b1, 0);
    expPush(8'h02, 1'b1, 1, 1'b0, 0); expPush(8'h03, 1'b1, 2, 1'b0, 0);
    expPush(8'h01, 1'b1, 0, 1'b0, 0); expPush(8'h05, 1'b1, 1, 1'b0, 0);
    expPush(8'h06, 1'b1, 2, 1'b0, 0); expPush(8'h04, 1'b1, 0, 1'b0, 0);
    runDrain("t2_drained", 100);

    // source 1 stalls mid-frame: abort filler, remainder flushed silently
    srcPush(1, 8'h11, 1'b0, 0); srcPush(1, 8'h22, 1'b0, 20); srcPush(1, 8'h33, 1'b1, 0);
    expPush(8'h11, 1'b0, 1, 1'b0, 0); expPush(8'h00, 1'b1, 1, 1'b1, 1);
    runDrain("t3_drained", 100);
    check("t3_count", abortCount, 1);
    check("t3_strobe_cycles", strobeCycles, 1);

    // long backpressure with a valid source is never treated as a stall
    srcPush(0, 8'hA1, 1'b0, 0); srcPush(0, 8'hA2, 1'b0, 0);
    srcPush(0, 8'hA3, 1'b0, 0); srcPush(0, 8'hA4, 1'b1, 0);
    expPush(8'hA1, 1'b0, 0, 1'b0, 0); expPush(8'hA2, 1'b0, 0, 1'b0, 0);
    expPush(8'hA3, 1'b0, 0, 1'b0, 0); expPush(8'hA4, 1'b1, 0, 1'b0, 0);
    n = 0;
    while (srcQ[0].size() > 2 && n < 20) begin step(); n++; end
    check("t4_progress", srcQ[0].size(), 2);
    mReady = 1'b0;
    repeat (5000) step();
    cycleBegin();
    check("t4_busy", busy, 1);
    check("t4_mvalid", mValid, 1);
    check("t4_mdata_held", mData, 8'hA3);
    check("t4_no_abort", abortCount, 1);
    cycleEnd();
    mReady = 1'b1;
    runDrain("t4_drained", 50);
    check("t4_strobe_cycles", strobeCycles, 1);

    // source 3 stalls and never finishes: flush times out, tail arrives as new frame
    srcPush(3, 8'h77, 1'b0, 0); srcPush(3, 8'h88, 1'b1, 60);
    expPush(8'h77, 1'b0, 3, 1'b0, 0); expPush(8'h00, 1'b1, 3, 1'b1, 2);
    expPush(8'h88, 1'b1, 3, 1'b0, 0);
    runDrain("t5_drained", 150);
    check("t5_count", abortCount, 2);
    check("t5_strobe_cycles", strobeCycles, 2);

    // asynchronous reset mid-frame after 2 of 4 bytes
    srcPush(2, 8'hC1, 1'b0, 0); srcPush(2, 8'hC2, 1'b0, 0);
    srcPush(2, 8'hC3, 1'b0, 0); srcPush(2, 8'hC4, 1'b1, 0);
    expPush(8'hC1, 1'b0, 2, 1'b0, 0); expPush(8'hC2, 1'b0, 2, 1'b0, 0);
    n = 0;
    while (srcQ[2].size() > 2 && n < 20) begin step(); n++; end
    check("t6_progress", srcQ[2].size(), 2);
    #2;
    check("t6_pre_reset_mvalid", mValid, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_mvalid", mValid, 0);
    check("t6_rst_mlast", mLast, 0);
    check("t6_rst_sready", sReady, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_grant", grant, N - 1);
    check("t6_rst_count", abortCount, 0);
    for (int i = 0; i < N; i++) srcQ[i].delete();
    sValid = '0; sData = '0; sLast = '0;
    cycleEnd();
    cycleEnd();
    reset_n = 1'b1;
    prevLast = 1'b1;
    lastEnd = -100;
    srcPush(1, 8'hD1, 1'b1, 0); srcPush(3, 8'hD3, 1'b1, 0);
    expPush(8'hD1, 1'b1, 1, 1'b0, 0); expPush(8'hD3, 1'b1, 3, 1'b0, 0);
    runDrain("t6_drained", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
